// File: rtl/td4_sequencer.sv
// TD4-class 4-bit sequencer: fetches from an external 16x8 ROM at PC and executes
// one instruction per enable, either at a divided run rate or on a step edge.
module td4_sequencer #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    output logic [3:0] rom_address,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic       carry,
    output logic       retire
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_IN_A  = 4'b0010;
    localparam logic [3:0] OP_IN_B  = 4'b0110;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1111;
    localparam logic [3:0] OP_JNC   = 4'b1110;

    logic [3:0]       r_pc;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic             r_c;
    logic [3:0]       r_out;
    logic [DIV_W-1:0] r_div;
    logic             r_step_d;
    logic             r_retire;

    logic             w_exec_en;
    logic [3:0]       w_op;
    logic [3:0]       w_im;
    logic [3:0]       w_src;
    logic [4:0]       w_sum;
    logic [3:0]       w_pc_next;
    logic [3:0]       w_a_next;
    logic [3:0]       w_b_next;
    logic [3:0]       w_out_next;
    logic             w_c_next;

    assign w_op = rom_data[7:4];
    assign w_im = rom_data[3:0];

    // Step edges only count in step mode; the divider alone paces run mode.
    assign w_exec_en = run ? (r_div == DIV_LAST) : (step & ~r_step_d);

    always_comb begin
        w_src      = (w_op == OP_ADD_B) ? r_b : r_a;
        w_sum      = {1'b0, w_src} + {1'b0, w_im};
        w_pc_next  = r_pc + 4'd1;
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_out_next = r_out;
        w_c_next   = 1'b0;
        case (w_op)
            OP_ADD_A: begin
                w_a_next = w_sum[3:0];
                w_c_next = w_sum[4];
            end
            OP_ADD_B: begin
                w_b_next = w_sum[3:0];
                w_c_next = w_sum[4];
            end
            OP_MOV_AI: w_a_next   = w_im;
            OP_MOV_BI: w_b_next   = w_im;
            OP_MOV_AB: w_a_next   = r_b;
            OP_MOV_BA: w_b_next   = r_a;
            OP_IN_A:   w_a_next   = in_port;
            OP_IN_B:   w_b_next   = in_port;
            OP_OUT_I:  w_out_next = w_im;
            OP_OUT_B:  w_out_next = r_b;
            OP_JMP:    w_pc_next  = w_im;
            OP_JNC:    w_pc_next  = r_c ? (r_pc + 4'd1) : w_im;
            default:   ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_out    <= '0;
            r_div    <= '0;
            r_step_d <= 1'b0;
            r_retire <= 1'b0;
        end else begin
            r_step_d <= step;
            r_retire <= w_exec_en;
            if (!run || r_div == DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_exec_en) begin
                r_pc  <= w_pc_next;
                r_a   <= w_a_next;
                r_b   <= w_b_next;
                r_c   <= w_c_next;
                r_out <= w_out_next;
            end
        end
    end

    assign rom_address = r_pc;
    assign out_port    = r_out;
    assign carry       = r_c;
    assign retire      = r_retire;

endmodule

// File: tb/tb_td4_sequencer.sv
// Bench for td4_sequencer: two instances (CLK_DIV=1 and 4) share one ROM image and
// are checked every cycle against an instruction-level reference model.
module tb_td4_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] in_port = 4'h0;
    logic [7:0] rom [16];

    logic [3:0] addr1, addr4, out1, out4;
    logic       c1, c4, ret1, ret4;
    logic [7:0] rd1, rd4;

    always #5 clk = ~clk;

    assign rd1 = rom[addr1];
    assign rd4 = rom[addr4];

    td4_sequencer #(.CLK_DIV(1)) u_dut1 (
        .clock(clk), .reset(reset), .run(run), .step(step),
        .rom_address(addr1), .rom_data(rd1), .in_port(in_port),
        .out_port(out1), .carry(c1), .retire(ret1)
    );

    td4_sequencer #(.CLK_DIV(4)) u_dut4 (
        .clock(clk), .reset(reset), .run(run), .step(step),
        .rom_address(addr4), .rom_data(rd4), .in_port(in_port),
        .out_port(out4), .carry(c4), .retire(ret4)
    );

    int per [2] = '{1, 4};
    int m_pc [2], m_a [2], m_b [2], m_c [2], m_out [2], m_ret [2], m_cnt [2], m_sp [2];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int rc1     = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic execute(input int d, input int w);
        int op, im, s, npc, cold;
        op   = w / 16;
        im   = w % 16;
        cold = m_c[d];
        npc  = (m_pc[d] + 1) % 16;
        m_c[d] = 0;
        case (op)
            0:  begin s = m_a[d] + im; m_c[d] = (s > 15); m_a[d] = s % 16; end
            5:  begin s = m_b[d] + im; m_c[d] = (s > 15); m_b[d] = s % 16; end
            3:  m_a[d] = im;
            7:  m_b[d] = im;
            1:  m_a[d] = m_b[d];
            4:  m_b[d] = m_a[d];
            2:  m_a[d] = int'(in_port);
            6:  m_b[d] = int'(in_port);
            11: m_out[d] = im;
            9:  m_out[d] = m_b[d];
            15: npc = im;
            14: if (cold == 0) npc = im;
            default: ;
        endcase
        m_pc[d] = npc;
    endtask

    task automatic model_cycle(input int d);
        int ex;
        if (reset) begin
            m_pc[d] = 0; m_a[d] = 0; m_b[d] = 0; m_c[d] = 0; m_out[d] = 0;
            m_ret[d] = 0; m_cnt[d] = 0; m_sp[d] = 0;
        end else begin
            if (run) ex = (m_cnt[d] == per[d] - 1) ? 1 : 0;
            else     ex = (step && m_sp[d] == 0) ? 1 : 0;
            m_cnt[d] = run ? (m_cnt[d] + 1) % per[d] : 0;
            m_sp[d]  = int'(step);
            m_ret[d] = ex;
            if (ex != 0) execute(d, int'(rom[m_pc[d]]));
        end
    endtask

    task automatic tick();
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
        check("pc_div1",     8'(addr1), 8'(m_pc[0]));
        check("out_div1",    8'(out1),  8'(m_out[0]));
        check("carry_div1",  8'(c1),    8'(m_c[0]));
        check("retire_div1", 8'(ret1),  8'(m_ret[0]));
        check("pc_div4",     8'(addr4), 8'(m_pc[1]));
        check("out_div4",    8'(out4),  8'(m_out[1]));
        check("carry_div4",  8'(c4),    8'(m_c[1]));
        check("retire_div4", 8'(ret4),  8'(m_ret[1]));
        if (ret1) rc1++;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    initial begin
        // Output-port walk with jump back to 0
        rom = '{0: 8'hB0, 1: 8'hB1, 2: 8'hB2, 3: 8'hB4, 4: 8'hB8, 5: 8'hF0, default: 8'h00};
        run = 1'b1;
        reset = 1'b1;
        tick();
        check("rst_pc",     8'(addr1), 8'h0);
        check("rst_out",    8'(out1),  8'h0);
        check("rst_carry",  8'(c1),    8'h0);
        check("rst_retire", 8'(ret1),  8'h0);
        reset = 1'b0;
        repeat (6) tick();
        check("walk_pc_wrap", 8'(addr1), 8'h0);
        check("walk_out8",    8'(out1),  8'h8);
        repeat (2) tick();
        check("walk_repeat",  8'(out1),  8'h1);
        check("div4_pc",      8'(addr4), 8'h2);
        check("div4_retire",  8'(ret4),  8'h1);
        tick();
        check("div4_gap",     8'(ret4),  8'h0);

        // Step held high executes once per rising edge
        run = 1'b0;
        reset_pulse();
        rc1 = 0;
        step = 1'b1;
        repeat (10) tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (2) tick();
        check("step_retires", 8'(rc1),   8'd2);
        check("step_pc",      8'(addr1), 8'h2);
        check("step_pc_div4", 8'(addr4), 8'h2);

        // JNC taken without carry
        rom = '{0: 8'h3E, 1: 8'h01, 2: 8'hE0, default: 8'h00};
        reset_pulse();
        repeat (3) pulse();
        check("jnc_taken_pc", 8'(addr1), 8'h0);
        check("jnc_taken_c",  8'(c1),    8'h0);

        // ADD overflow sets carry, JNC falls through
        rom = '{0: 8'h3F, 1: 8'h01, 2: 8'hE0, default: 8'h00};
        reset_pulse();
        repeat (2) pulse();
        check("add_ovf_c",    8'(c1),    8'h1);
        pulse();
        check("jnc_fall_pc",  8'(addr1), 8'h3);
        check("jnc_fall_c",   8'(c1),    8'h0);

        // IN A, MOV B,A, OUT B
        rom = '{0: 8'h23, 1: 8'h40, 2: 8'h90, default: 8'h00};
        in_port = 4'hA;
        reset_pulse();
        repeat (3) pulse();
        check("in_mov_out",   8'(out1),  8'hA);
        check("in_mov_c",     8'(c1),    8'h0);

        // Reset mid-run with live state
        rom = '{0: 8'h35, 1: 8'hB8, 2: 8'h80, 3: 8'h80, 4: 8'h80, 5: 8'h80, 6: 8'h80,
                default: 8'h00};
        run = 1'b1;
        reset_pulse();
        repeat (7) tick();
        check("mid_pc7",      8'(addr1), 8'h7);
        check("mid_out8",     8'(out1),  8'h8);
        reset = 1'b1;
        tick();
        check("mid_rst_pc",   8'(addr1), 8'h0);
        check("mid_rst_out",  8'(out1),  8'h0);
        check("mid_rst_ret",  8'(ret1),  8'h0);
        check("mid_rst_pc4",  8'(addr4), 8'h0);
        reset = 1'b0;
        tick();
        check("resume_ret1",  8'(ret1),  8'h1);
        check("resume_pc1",   8'(addr1), 8'h1);
        repeat (3) tick();
        check("resume_ret4",  8'(ret4),  8'h1);
        check("resume_pc4",   8'(addr4), 8'h1);

        // Random programs, inputs, mode changes and resets
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 500; n++) begin
            if (n == 250) begin
                for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 7) == 0) run = ~run;
            step    = 1'($urandom_range(0, 1));
            in_port = 4'($urandom_range(0, 15));
            reset   = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
